// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller for the 5-stage pipeline.
// Tracks the register fields of the instructions in EX, MEM and WB and
// derives the load-use stall, the branch flush and the EX operand
// forwarding selects. Also keeps saturating stall/flush event counters.
module hazard_fwd_ctrl #(
    parameter int REG_W    = 5,
    parameter int ZERO_REG = 31,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic             id_rn_used,
    input  logic             id_rm_used,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             ex_br_taken,
    output logic             stall,
    output logic             flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [REG_W-1:0] ZERO_ADDR = REG_W'(ZERO_REG);
    localparam logic [1:0] SEL_REGFILE = 2'b00;
    localparam logic [1:0] SEL_WB      = 2'b01;
    localparam logic [1:0] SEL_MEM     = 2'b10;

    // EX stage shadow
    logic [REG_W-1:0] ex_rn;
    logic [REG_W-1:0] ex_rm;
    logic             ex_rn_used;
    logic             ex_rm_used;
    logic [REG_W-1:0] ex_rd;
    logic             ex_reg_write;
    logic             ex_mem_read;
    // MEM stage shadow
    logic [REG_W-1:0] mem_rd;
    logic             mem_reg_write;
    // WB stage shadow
    logic [REG_W-1:0] wb_rd;
    logic             wb_reg_write;

    logic load_use;
    logic bubble;

    // Load-use detection, flush, and flush-over-stall priority.
    always_comb begin
        load_use = ex_mem_read && (ex_rd != ZERO_ADDR) &&
                   ((id_rn_used && (id_rn == ex_rd)) ||
                    (id_rm_used && (id_rm == ex_rd)));
        flush    = ex_br_taken;
        stall    = load_use && !ex_br_taken;
        bubble   = stall || flush;
    end

    // Operand forwarding: MEM result beats WB result; XZR never forwards.
    always_comb begin
        fwd_a = SEL_REGFILE;
        fwd_b = SEL_REGFILE;
        if (ex_rn_used && mem_reg_write && (mem_rd == ex_rn) && (mem_rd != ZERO_ADDR))
            fwd_a = SEL_MEM;
        else if (ex_rn_used && wb_reg_write && (wb_rd == ex_rn) && (wb_rd != ZERO_ADDR))
            fwd_a = SEL_WB;
        if (ex_rm_used && mem_reg_write && (mem_rd == ex_rm) && (mem_rd != ZERO_ADDR))
            fwd_b = SEL_MEM;
        else if (ex_rm_used && wb_reg_write && (wb_rd == ex_rm) && (wb_rd != ZERO_ADDR))
            fwd_b = SEL_WB;
    end

    // EX shadow: capture ID fields, or a bubble on stall/flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_rn        <= '0;
            ex_rm        <= '0;
            ex_rn_used   <= 1'b0;
            ex_rm_used   <= 1'b0;
            ex_rd        <= '0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
        end else if (bubble) begin
            ex_rn        <= '0;
            ex_rm        <= '0;
            ex_rn_used   <= 1'b0;
            ex_rm_used   <= 1'b0;
            ex_rd        <= '0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
        end else begin
            ex_rn        <= id_rn;
            ex_rm        <= id_rm;
            ex_rn_used   <= id_rn_used;
            ex_rm_used   <= id_rm_used;
            ex_rd        <= id_rd;
            ex_reg_write <= id_reg_write;
            ex_mem_read  <= id_mem_read;
        end
    end

    // MEM and WB shadows always advance; the branching EX entry moves on normally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_rd        <= '0;
            mem_reg_write <= 1'b0;
            wb_rd         <= '0;
            wb_reg_write  <= 1'b0;
        end else begin
            mem_rd        <= ex_rd;
            mem_reg_write <= ex_reg_write;
            wb_rd         <= mem_rd;
            wb_reg_write  <= mem_reg_write;
        end
    end

    // Saturating event counters; they stick at all-ones rather than wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush && (flush_cnt != {CNT_W{1'b1}}))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed testbench for hazard_fwd_ctrl. Counters are reduced to 2 bits
// so saturation is reached within a few load-use pairs.
module tb_hazard_fwd_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] id_rn;
    logic [4:0] id_rm;
    logic       id_rn_used;
    logic       id_rm_used;
    logic [4:0] id_rd;
    logic       id_reg_write;
    logic       id_mem_read;
    logic       ex_br_taken;
    logic       stall;
    logic       flush;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic [1:0] stall_cnt;
    logic [1:0] flush_cnt;

    int n_checks = 0;
    int n_fails  = 0;

    hazard_fwd_ctrl #(
        .REG_W(5),
        .ZERO_REG(31),
        .CNT_W(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .id_rn(id_rn),
        .id_rm(id_rm),
        .id_rn_used(id_rn_used),
        .id_rm_used(id_rm_used),
        .id_rd(id_rd),
        .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read),
        .ex_br_taken(ex_br_taken),
        .stall(stall),
        .flush(flush),
        .fwd_a(fwd_a),
        .fwd_b(fwd_b),
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // checking task
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic drive_id(input logic [4:0] rn, input logic rn_u,
                            input logic [4:0] rm, input logic rm_u,
                            input logic [4:0] rd, input logic rw, input logic mr);
        id_rn        = rn;
        id_rn_used   = rn_u;
        id_rm        = rm;
        id_rm_used   = rm_u;
        id_rd        = rd;
        id_reg_write = rw;
        id_mem_read  = mr;
    endtask

    task automatic drive_idle();
        drive_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // let combinational outputs settle after driving inputs
    task automatic settle();
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        ex_br_taken = 1'b0;
        drive_idle();
        #12;
        check_eq("rst_stall", {31'd0, stall}, 32'd0);
        check_eq("rst_flush", {31'd0, flush}, 32'd0);
        check_eq("rst_fwd_a", {30'd0, fwd_a}, 32'd0);
        check_eq("rst_fwd_b", {30'd0, fwd_b}, 32'd0);
        check_eq("rst_stall_cnt", {30'd0, stall_cnt}, 32'd0);
        check_eq("rst_flush_cnt", {30'd0, flush_cnt}, 32'd0);
        reset = 1'b0;
        tick();

        // Load-use: LDUR X1,[X10] then ADD X2,X1,X3
        drive_id(5'd10, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 1'b1);
        settle();
        check_eq("lu_no_stall_first", {31'd0, stall}, 32'd0);
        tick();
        drive_id(5'd1, 1'b1, 5'd3, 1'b1, 5'd2, 1'b1, 1'b0);
        settle();
        check_eq("lu_stall", {31'd0, stall}, 32'd1);
        tick();
        settle();
        check_eq("lu_stall_released", {31'd0, stall}, 32'd0);
        tick();
        drive_idle();
        settle();
        check_eq("lu_fwd_a_wb", {30'd0, fwd_a}, 32'd1);
        check_eq("lu_fwd_b_none", {30'd0, fwd_b}, 32'd0);
        check_eq("lu_stall_cnt", {30'd0, stall_cnt}, 32'd1);
        tick();

        // ADD X1,X2,X3 then SUB X4,X1,X1
        drive_id(5'd2, 1'b1, 5'd3, 1'b1, 5'd1, 1'b1, 1'b0);
        tick();
        drive_id(5'd1, 1'b1, 5'd1, 1'b1, 5'd4, 1'b1, 1'b0);
        settle();
        check_eq("alu_no_stall", {31'd0, stall}, 32'd0);
        tick();
        drive_idle();
        settle();
        check_eq("alu_fwd_a_mem", {30'd0, fwd_a}, 32'd2);
        check_eq("alu_fwd_b_mem", {30'd0, fwd_b}, 32'd2);
        tick();

        // ADD X5 (to WB), ORR X5 (to MEM), consumer reads X5 on Rm
        drive_id(5'd2, 1'b1, 5'd3, 1'b1, 5'd5, 1'b1, 1'b0);
        tick();
        drive_id(5'd8, 1'b1, 5'd9, 1'b1, 5'd5, 1'b1, 1'b0);
        tick();
        drive_id(5'd7, 1'b1, 5'd5, 1'b1, 5'd10, 1'b1, 1'b0);
        tick();
        drive_idle();
        settle();
        check_eq("prio_fwd_b_mem", {30'd0, fwd_b}, 32'd2);
        check_eq("prio_fwd_a_none", {30'd0, fwd_a}, 32'd0);
        tick();

        // LDUR X31 then ADD reading X31 on both operands
        drive_id(5'd10, 1'b1, 5'd0, 1'b0, 5'd31, 1'b1, 1'b1);
        tick();
        drive_id(5'd31, 1'b1, 5'd31, 1'b1, 5'd11, 1'b1, 1'b0);
        settle();
        check_eq("xzr_no_stall", {31'd0, stall}, 32'd0);
        tick();
        drive_idle();
        settle();
        check_eq("xzr_fwd_a", {30'd0, fwd_a}, 32'd0);
        check_eq("xzr_fwd_b", {30'd0, fwd_b}, 32'd0);
        check_eq("xzr_stall_cnt", {30'd0, stall_cnt}, 32'd1);
        tick();

        // Load-use together with a taken branch: flush wins
        drive_id(5'd10, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1);
        tick();
        drive_id(5'd3, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0);
        ex_br_taken = 1'b1;
        settle();
        check_eq("br_flush", {31'd0, flush}, 32'd1);
        check_eq("br_no_stall", {31'd0, stall}, 32'd0);
        tick();
        ex_br_taken = 1'b0;
        drive_idle();
        settle();
        check_eq("br_flush_clear", {31'd0, flush}, 32'd0);
        check_eq("br_bubble_fwd_a", {30'd0, fwd_a}, 32'd0);
        check_eq("br_flush_cnt", {30'd0, flush_cnt}, 32'd1);
        check_eq("br_stall_cnt", {30'd0, stall_cnt}, 32'd1);

        // Self-dependent load repeated: stalls every other cycle
        drive_id(5'd1, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            settle();
            check_eq("rep_stall_pattern", {31'd0, stall}, (i % 2 == 1) ? 32'd1 : 32'd0);
            tick();
        end
        check_eq("sat_stall_cnt", {30'd0, stall_cnt}, 32'd3);
        tick();
        settle();
        check_eq("sat_stall_again", {31'd0, stall}, 32'd1);
        tick();
        check_eq("sat_no_wrap", {30'd0, stall_cnt}, 32'd3);
        tick();
        settle();
        check_eq("mid_stall", {31'd0, stall}, 32'd1);

        // Reset asserted in the middle of a stall
        reset = 1'b1;
        settle();
        check_eq("mid_rst_stall", {31'd0, stall}, 32'd0);
        check_eq("mid_rst_stall_cnt", {30'd0, stall_cnt}, 32'd0);
        check_eq("mid_rst_flush_cnt", {30'd0, flush_cnt}, 32'd0);
        check_eq("mid_rst_fwd_a", {30'd0, fwd_a}, 32'd0);
        tick();
        reset = 1'b0;
        drive_idle();
        settle();
        check_eq("post_rst_stall", {31'd0, stall}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
